lap_stopwatch: RTL and testbench



---
 rtl/lap_stopwatch.sv | 216 +++++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stopwatch.sv
// Stopwatch with a circular lap memory and lap recall.
// Build option LAP_SPLIT_EN: store split times instead of cumulative times.
module lap_stopwatch #(
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned MIN_LIMIT = 99,
    parameter int unsigned IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic             next,
    output logic [6:0]       disp_min,
    output logic [6:0]       disp_sec,
    output logic [6:0]       disp_cs,
    output logic [IDX_W-1:0] disp_idx,
    output logic [IDX_W:0]   lap_count,
    output logic             running,
    output logic             recall,
    output logic             lap_full,
    output logic             overflow
);

    localparam int unsigned TW = 7;
    localparam int unsigned CW = IDX_W + 1;

    typedef struct packed {
        logic [TW-1:0] mn;
        logic [TW-1:0] sc;
        logic [TW-1:0] cs;
    } stamp_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_RECALL} state_t;

    state_t           state_q, state_d;
    stamp_t           live_q, live_d;
    stamp_t           disp_d;
    stamp_t           cap_val;
    stamp_t           mem [LAP_DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] idx_d, phys;
    logic [CW-1:0]    cnt_d, phys_sum;
    logic             full_d, ovf_d, cap, clr_ok;
    logic             running_d, recall_d;

`ifdef LAP_SPLIT_EN
    stamp_t prev_q, prev_d;

    // Mixed-radix a - b, modulo one full counter period.
    function automatic stamp_t sub_t(input stamp_t a, input stamp_t b);
        stamp_t r;
        int     d;
        int     br;
        d  = int'(a.cs) - int'(b.cs);
        br = 0;
        if (d < 0) begin d = d + 100; br = 1; end
        r.cs = TW'(d);
        d  = int'(a.sc) - int'(b.sc) - br;
        br = 0;
        if (d < 0) begin d = d + 60; br = 1; end
        r.sc = TW'(d);
        d  = int'(a.mn) - int'(b.mn) - br;
        if (d < 0) d = d + int'(MIN_LIMIT) + 1;
        r.mn = TW'(d);
        return r;
    endfunction
`endif

    // State register; mode flags registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            running <= 1'b0;
            recall  <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= running_d;
            recall  <= recall_d;
        end
    end

    // Next-state logic; clear outranks start_stop, which outranks next.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!clear && start_stop) state_d = S_RUN;
            S_RUN:    if (start_stop) state_d = S_STOP;
            S_STOP: begin
                if (clear)                               state_d = S_IDLE;
                else if (start_stop)                     state_d = S_RUN;
                else if (next && lap_count != CW'(0))    state_d = S_STOP == S_STOP ? S_RECALL : S_STOP;
            end
            S_RECALL: begin
                if (clear)           state_d = S_IDLE;
                else if (start_stop) state_d = S_STOP;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Counter, lap bookkeeping, recall index and display selection.
    always_comb begin
        live_d    = live_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = lap_count;
        full_d    = lap_full;
        ovf_d     = overflow;
        cap       = 1'b0;
        idx_d     = '0;
        phys_sum  = '0;
        phys      = '0;
        disp_d    = '0;
        running_d = (state_d == S_RUN);
        recall_d  = (state_d == S_RECALL);
        clr_ok    = clear && (state_q != S_RUN);
`ifdef LAP_SPLIT_EN
        prev_d  = prev_q;
        cap_val = sub_t(live_q, prev_q);
`else
        cap_val = live_q;
`endif

        if (clr_ok) begin
            live_d   = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            full_d   = 1'b0;
            ovf_d    = 1'b0;
`ifdef LAP_SPLIT_EN
            prev_d   = '0;
`endif
        end else if (state_q == S_RUN) begin
            if (lap && !start_stop) begin
                cap      = 1'b1;
                wr_ptr_d = (wr_ptr_q == IDX_W'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
                if (lap_count == CW'(LAP_DEPTH)) full_d = 1'b1;
                else                             cnt_d  = lap_count + CW'(1);
`ifdef LAP_SPLIT_EN
                prev_d   = live_q;
`endif
            end
            if (tick) begin
                if (live_q.cs == TW'(99)) begin
                    live_d.cs = '0;
                    if (live_q.sc == TW'(59)) begin
                        live_d.sc = '0;
                        if (live_q.mn == TW'(MIN_LIMIT)) begin
                            live_d.mn = '0;
                            ovf_d     = 1'b1;
                        end else begin
                            live_d.mn = live_q.mn + TW'(1);
                        end
                    end else begin
                        live_d.sc = live_q.sc + TW'(1);
                    end
                end else begin
                    live_d.cs = live_q.cs + TW'(1);
                end
            end
        end

        // Logical index 0 is the oldest entry; newest sits at lap_count-1.
        if (state_d == S_RECALL) begin
            if (state_q != S_RECALL)                 idx_d = IDX_W'(lap_count - CW'(1));
            else if (!next)                          idx_d = disp_idx;
            else if (disp_idx == '0)                 idx_d = IDX_W'(lap_count - CW'(1));
            else                                     idx_d = disp_idx - IDX_W'(1);
        end

        phys_sum = lap_full ? CW'(wr_ptr_q) + CW'(idx_d) : CW'(idx_d);
        if (phys_sum >= CW'(LAP_DEPTH)) phys_sum = phys_sum - CW'(LAP_DEPTH);
        phys = IDX_W'(phys_sum);

        disp_d = (state_d == S_RECALL) ? mem[phys] : live_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q    <= '0;
            wr_ptr_q  <= '0;
            lap_count <= '0;
            lap_full  <= 1'b0;
            overflow  <= 1'b0;
            disp_idx  <= '0;
            disp_min  <= '0;
            disp_sec  <= '0;
            disp_cs   <= '0;
        end else begin
            live_q    <= live_d;
            wr_ptr_q  <= wr_ptr_d;
            lap_count <= cnt_d;
            lap_full  <= full_d;
            overflow  <= ovf_d;
            disp_idx  <= idx_d;
            disp_min  <= disp_d.mn;
            disp_sec  <= disp_d.sc;
            disp_cs   <= disp_d.cs;
        end
    end

`ifdef LAP_SPLIT_EN
    always_ff @(posedge clk) begin
        if (rst) prev_q <= '0;
        else     prev_q <= prev_d;
    end
`endif

    // Lap storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && cap) mem[wr_ptr_q] <= cap_val;
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch against a centisecond-count reference model.
// Honours LAP_SPLIT_EN the same way as the design.
module tb_lap_stopwatch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ML    = 1;
    localparam int unsigned IW    = 2;
    localparam int          P     = (ML + 1) * 6000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0, next = 1'b0;
    logic [6:0]    disp_min, disp_sec, disp_cs;
    logic [IW-1:0] disp_idx;
    logic [IW:0]   lap_count;
    logic          running, recall, lap_full, overflow;

    int checks = 0;
    int passed = 0;

    // Reference model: time as total centiseconds, laps as a queue (front = oldest).
    int ms = 0;     // 0 idle, 1 run, 2 stop, 3 recall
    int mt = 0;
    int mq[$];
    bit mfull = 0;
    bit movf = 0;
    int midx = 0;
    int mprev = 0;

    lap_stopwatch #(.LAP_DEPTH(DEPTH), .MIN_LIMIT(ML), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap),
        .clear(clear), .next(next), .disp_min(disp_min), .disp_sec(disp_sec),
        .disp_cs(disp_cs), .disp_idx(disp_idx), .lap_count(lap_count),
        .running(running), .recall(recall), .lap_full(lap_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic m_clear();
        ms = 0; mt = 0; mq.delete(); mfull = 0; movf = 0; midx = 0; mprev = 0;
    endtask

    task automatic m_capture();
        int v;
`ifdef LAP_SPLIT_EN
        v = (mt - mprev + P) % P;
`else
        v = mt;
`endif
        mprev = mt;
        if (mq.size() == DEPTH) begin
            void'(mq.pop_front());
            mfull = 1;
        end
        mq.push_back(v);
    endtask

    task automatic m_update(input bit ss, input bit lp, input bit clr, input bit nx,
                            input bit tk, input bit r);
        if (r) m_clear();
        else case (ms)
            0: if (clr) m_clear(); else if (ss) ms = 1;
            1: begin
                if (lp && !ss) m_capture();
                if (tk) begin
                    mt = mt + 1;
                    if (mt == P) begin mt = 0; movf = 1; end
                end
                if (ss) ms = 2;
            end
            2: if (clr) m_clear();
               else if (ss) ms = 1;
               else if (nx && mq.size() > 0) begin ms = 3; midx = mq.size() - 1; end
            default: if (clr) m_clear();
               else if (ss) begin ms = 2; midx = 0; end
               else if (nx) midx = (midx == 0) ? mq.size() - 1 : midx - 1;
        endcase
    endtask

    function automatic logic [20:0] m_disp();
        int v;
        v = (ms == 3) ? mq[midx] : mt;
        return {7'(v / 6000), 7'((v / 100) % 60), 7'(v % 100)};
    endfunction

    // One clock cycle with the given pulses; outputs sampled 1 time unit after the edge.
    task automatic step(input bit ss, input bit lp, input bit clr, input bit nx,
                        input bit tk, input bit r);
        start_stop = ss; lap = lp; clear = clr; next = nx; tick = tk; rst = r;
        m_update(ss, lp, clr, nx, tk, r);
        @(posedge clk);
        #1;
        start_stop = 0; lap = 0; clear = 0; next = 0; tick = 0; rst = 0;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({disp_min, disp_sec, disp_cs, disp_idx, lap_count, running, recall, lap_full, overflow} !== '0)
            $display("FAIL reset_outputs: got %0d:%0d:%0d idx=%0d cnt=%0d run=%b rec=%b full=%b ovf=%b want all 0",
                     disp_min, disp_sec, disp_cs, disp_idx, lap_count, running, recall, lap_full, overflow);
        else passed++;
    endtask

    task automatic test_basic_count();
        step(1, 0, 0, 0, 0, 0);
        repeat (150) step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, running} !== {7'd0, 7'd1, 7'd50, 1'b1})
            $display("FAIL basic_count: got %0d:%0d:%0d run=%b want 0:1:50 run=1",
                     disp_min, disp_sec, disp_cs, running);
        else passed++;
    endtask

    task automatic test_lap_with_tick();
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        repeat (99) step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, lap_count} !== {7'd0, 7'd1, 7'd0, 3'd1})
            $display("FAIL lap_tick_live: got %0d:%0d:%0d cnt=%0d want 0:1:0 cnt=1",
                     disp_min, disp_sec, disp_cs, lap_count);
        else passed++;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, disp_idx, recall, running} !== {7'd0, 7'd0, 7'd99, 2'd0, 1'b1, 1'b0})
            $display("FAIL lap_tick_stored: got %0d:%0d:%0d idx=%0d rec=%b run=%b want 0:0:99 idx=0 rec=1 run=0",
                     disp_min, disp_sec, disp_cs, disp_idx, recall, running);
        else passed++;
    endtask

    task automatic test_lap_wrap();
        logic [6:0] exp_cs [5];
        logic [1:0] exp_idx [5];
`ifdef LAP_SPLIT_EN
        exp_cs  = '{7'd10, 7'd10, 7'd10, 7'd10, 7'd10};
`else
        exp_cs  = '{7'd50, 7'd40, 7'd30, 7'd20, 7'd50};
`endif
        exp_idx = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            repeat (10) step(0, 0, 0, 0, 1, 0);
            step(0, 1, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 0, 0);
            checks++;
            if ({disp_cs, disp_idx, lap_full, lap_count} !== {exp_cs[k], exp_idx[k], 1'b1, 3'd4})
                $display("FAIL lap_wrap_%0d: got cs=%0d idx=%0d full=%b cnt=%0d want cs=%0d idx=%0d full=1 cnt=4",
                         k, disp_cs, disp_idx, lap_full, lap_count, exp_cs[k], exp_idx[k]);
            else passed++;
        end
    endtask

    task automatic test_clear();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, running, lap_count, lap_full} !== {7'd0, 7'd0, 7'd50, 1'b1, 3'd4, 1'b1})
            $display("FAIL clear_in_run: got %0d:%0d:%0d run=%b cnt=%0d full=%b want 0:0:50 run=1 cnt=4 full=1",
                     disp_min, disp_sec, disp_cs, running, lap_count, lap_full);
        else passed++;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, disp_idx, lap_count, running, recall, lap_full, overflow} !== '0)
            $display("FAIL clear_in_stop: got %0d:%0d:%0d idx=%0d cnt=%0d run=%b rec=%b full=%b want all 0",
                     disp_min, disp_sec, disp_cs, disp_idx, lap_count, running, recall, lap_full);
        else passed++;
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({recall, disp_idx, running} !== {1'b0, 2'd0, 1'b0})
            $display("FAIL next_after_clear: got rec=%b idx=%0d run=%b want rec=0 idx=0 run=0",
                     recall, disp_idx, running);
        else passed++;
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        repeat (P - 1) step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, overflow} !== {7'd1, 7'd59, 7'd99, 1'b0})
            $display("FAIL pre_overflow: got %0d:%0d:%0d ovf=%b want 1:59:99 ovf=0",
                     disp_min, disp_sec, disp_cs, overflow);
        else passed++;
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, overflow, running} !== {7'd0, 7'd0, 7'd0, 1'b1, 1'b1})
            $display("FAIL overflow_wrap: got %0d:%0d:%0d ovf=%b run=%b want 0:0:0 ovf=1 run=1",
                     disp_min, disp_sec, disp_cs, overflow, running);
        else passed++;
    endtask

    task automatic test_split();
        logic [20:0] exp_new;
`ifdef LAP_SPLIT_EN
        exp_new = {7'd0, 7'd1, 7'd85};
`else
        exp_new = {7'd0, 7'd3, 7'd5};
`endif
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        repeat (120) step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (185) step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs} !== exp_new)
            $display("FAIL split_newest: got %0d:%0d:%0d want %0d:%0d:%0d",
                     disp_min, disp_sec, disp_cs, exp_new[20:14], exp_new[13:7], exp_new[6:0]);
        else passed++;
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({disp_min, disp_sec, disp_cs, disp_idx} !== {7'd0, 7'd1, 7'd20, 2'd0})
            $display("FAIL split_oldest: got %0d:%0d:%0d idx=%0d want 0:1:20 idx=0",
                     disp_min, disp_sec, disp_cs, disp_idx);
        else passed++;
    endtask

    task automatic test_random();
        logic [29:0] exp_v, act_v;
        int          shown = 0;
        step(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 499) == 0);
            exp_v = {m_disp(), IW'(midx), 3'(mq.size()), ms == 1, ms == 3, mfull, movf};
            act_v = {disp_min, disp_sec, disp_cs, disp_idx, lap_count, running, recall, lap_full, overflow};
            checks++;
            if (act_v !== exp_v) begin
                if (shown < 10)
                    $display("FAIL random_cycle_%0d: got %h want %h", n, act_v, exp_v);
                shown++;
            end else passed++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_count();
        test_lap_with_tick();
        test_lap_wrap();
        test_clear();
        test_overflow();
        test_split();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
